// File: rtl/sram_port_arbiter_if.sv
// Bundle of write-capture, pipeline-read and SRAM command/response signals
// seen by sram_port_arbiter (master side) and its environment (slave side).
interface sram_port_arbiter_if #(
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
);
    logic [NUM_WR-1:0]        wr_valid;
    logic [NUM_WR-1:0]        wr_ready;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [ADDR_W-1:0]        rd_addr;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_data_valid;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_we;
    logic [ADDR_W-1:0]        cmd_addr;
    logic [DATA_W-1:0]        cmd_wdata;
    logic                     rsp_valid;
    logic [DATA_W-1:0]        rsp_data;
    logic [NUM_WR-1:0]        wr_overflow;
    logic                     err_clear;

    modport master (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
               cmd_ready, rsp_valid, rsp_data, err_clear,
        output wr_ready, rd_ready, rd_data, rd_data_valid,
               cmd_valid, cmd_we, cmd_addr, cmd_wdata, wr_overflow
    );

    modport slave (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
               cmd_ready, rsp_valid, rsp_data, err_clear,
        input  wr_ready, rd_ready, rd_data, rd_data_valid,
               cmd_valid, cmd_we, cmd_addr, cmd_wdata, wr_overflow
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Merges NUM_WR buffered capture write streams and one priority read stream onto one SRAM command port.
// Optional read-starvation guard enabled by defining SRAM_ARB_STARVE_GUARD_EN.
module sram_port_arbiter #(
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
`ifdef SRAM_ARB_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_LIMIT = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_port_arbiter_if.master  bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CH_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic [ADDR_W-1:0] fifo_addr [NUM_WR][FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [NUM_WR][FIFO_DEPTH];

    logic [NUM_WR-1:0][PTR_W-1:0] head;
    logic [NUM_WR-1:0][PTR_W-1:0] tail;
    logic [NUM_WR-1:0][CNT_W-1:0] count;

    logic [NUM_WR-1:0] full_c;
    logic [NUM_WR-1:0] nonempty_c;
    logic [NUM_WR-1:0] push_c;
    logic [NUM_WR-1:0] pop_c;
    logic              any_nonempty_c;

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_ch_c;
    logic [CH_W-1:0]   cand_c;
    logic              found_c;
    logic              load_c;
    logic              rd_sel_c;
    logic              wr_sel_c;
    logic              force_wr_c;
    logic [ADDR_W-1:0] head_addr_c;
    logic [DATA_W-1:0] head_data_c;

    function automatic int unsigned wrap_ch(input int unsigned v);
        return (v >= NUM_WR) ? v - NUM_WR : v;
    endfunction

    // FIFO status from start-of-cycle state; a full FIFO refuses pushes even when popped this cycle
    always_comb begin
        full_c     = '0;
        nonempty_c = '0;
        push_c     = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            full_c[i]     = (count[i] == CNT_W'(FIFO_DEPTH));
            nonempty_c[i] = (count[i] != '0);
            push_c[i]     = bus.wr_valid[i] && !full_c[i];
        end
    end

    assign any_nonempty_c = |nonempty_c;
    assign bus.wr_ready   = ~full_c;

    // Round-robin search starting at rr_ptr
    always_comb begin
        grant_ch_c = rr_ptr;
        found_c    = 1'b0;
        cand_c     = '0;
        for (int unsigned off = 0; off < NUM_WR; off++) begin
            cand_c = CH_W'(wrap_ch(32'(rr_ptr) + off));
            if (!found_c && nonempty_c[cand_c]) begin
                found_c    = 1'b1;
                grant_ch_c = cand_c;
            end
        end
    end

    assign load_c       = !bus.cmd_valid || bus.cmd_ready;
    assign rd_sel_c     = load_c && bus.rd_valid && !force_wr_c;
    assign wr_sel_c     = load_c && any_nonempty_c && !rd_sel_c;
    assign pop_c        = wr_sel_c ? (NUM_WR'(1) << grant_ch_c) : '0;
    assign bus.rd_ready = rd_sel_c;
    assign head_addr_c  = fifo_addr[grant_ch_c][head[grant_ch_c]];
    assign head_data_c  = fifo_data[grant_ch_c][head[grant_ch_c]];

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] starve_cnt;

    // Counts reads that bypassed waiting writes; at the limit the next load must be a write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (wr_sel_c) begin
            starve_cnt <= '0;
        end else if (rd_sel_c && any_nonempty_c) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    assign force_wr_c = any_nonempty_c && (starve_cnt == SC_W'(STARVE_LIMIT));
`else
    assign force_wr_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (push_c[i]) tail[i] <= tail[i] + PTR_W'(1);
                if (pop_c[i])  head[i] <= head[i] + PTR_W'(1);
                count[i] <= count[i] + CNT_W'(push_c[i]) - CNT_W'(pop_c[i]);
            end
        end
    end

    // Storage is never read before being written, so it carries no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WR; i++) begin
            if (push_c[i]) begin
                fifo_addr[i][tail[i]] <= bus.wr_addr[i*ADDR_W +: ADDR_W];
                fifo_data[i][tail[i]] <= bus.wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_overflow <= '0;
        end else begin
            bus.wr_overflow <= (bus.err_clear ? '0 : bus.wr_overflow) | (bus.wr_valid & full_c);
        end
    end

    // Single-entry command register, reloadable in the cycle it is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cmd_valid <= 1'b0;
            bus.cmd_we    <= 1'b0;
            bus.cmd_addr  <= '0;
            bus.cmd_wdata <= '0;
            rr_ptr        <= '0;
        end else if (load_c) begin
            bus.cmd_valid <= rd_sel_c || wr_sel_c;
            if (rd_sel_c) begin
                bus.cmd_we    <= 1'b0;
                bus.cmd_addr  <= bus.rd_addr;
                bus.cmd_wdata <= '0;
            end else if (wr_sel_c) begin
                bus.cmd_we    <= 1'b1;
                bus.cmd_addr  <= head_addr_c;
                bus.cmd_wdata <= head_data_c;
                rr_ptr        <= (32'(grant_ch_c) == NUM_WR - 1) ? '0 : grant_ch_c + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data       <= '0;
            bus.rd_data_valid <= 1'b0;
        end else begin
            bus.rd_data       <= bus.rsp_data;
            bus.rd_data_valid <= bus.rsp_valid;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_sram_port_arbiter;
    localparam int NUM_WR       = 2;
    localparam int ADDR_W       = 20;
    localparam int DATA_W       = 16;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sram_port_arbiter_if #(.NUM_WR(NUM_WR), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_port_arbiter #(
        .NUM_WR(NUM_WR), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel queues, one command slot, round-robin start channel
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              fq [NUM_WR][$];
    bit                m_cv    = 1'b0;
    bit                m_we    = 1'b0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [DATA_W-1:0] m_wd    = '0;
    int                m_rr    = 0;
    logic [NUM_WR-1:0] m_ovf   = '0;
    bit                m_rdv   = 1'b0;
    logic [DATA_W-1:0] m_rdd   = '0;
    int                m_starve = 0;

    function automatic bit any_ne();
        for (int i = 0; i < NUM_WR; i++) if (fq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_force();
`ifdef SRAM_ARB_STARVE_GUARD_EN
        return (m_starve == STARVE_LIMIT) && any_ne();
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_rd_ready();
        return (!m_cv || bus.cmd_ready) && bus.rd_valid && !m_force();
    endfunction

    function automatic logic [NUM_WR-1:0] exp_ready();
        logic [NUM_WR-1:0] r;
        for (int i = 0; i < NUM_WR; i++) r[i] = fq[i].size() < DEPTH;
        return r;
    endfunction

    initial begin : model
        ent_t              e;
        logic [NUM_WR-1:0] full;
        bit                found;
        int                ch;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NUM_WR; i++) fq[i].delete();
                m_cv = 0; m_we = 0; m_addr = '0; m_wd = '0; m_rr = 0;
                m_ovf = '0; m_rdv = 0; m_rdd = '0; m_starve = 0;
            end else begin
                full = ~exp_ready();
                if (!m_cv || bus.cmd_ready) begin
                    if (bus.rd_valid && !m_force()) begin
                        if (any_ne()) m_starve++;
                        m_cv = 1; m_we = 0; m_addr = bus.rd_addr;
                    end else if (any_ne()) begin
                        found = 0;
                        ch = 0;
                        for (int k = 0; k < NUM_WR; k++) begin
                            if (!found && fq[(m_rr + k) % NUM_WR].size() != 0) begin
                                found = 1;
                                ch = (m_rr + k) % NUM_WR;
                            end
                        end
                        e = fq[ch].pop_front();
                        m_cv = 1; m_we = 1; m_addr = e.a; m_wd = e.d;
                        m_rr = (ch + 1) % NUM_WR;
                        m_starve = 0;
                    end else begin
                        m_cv = 0;
                    end
                end
                for (int i = 0; i < NUM_WR; i++) begin
                    if (bus.wr_valid[i] && !full[i]) begin
                        e.a = bus.wr_addr[i*ADDR_W +: ADDR_W];
                        e.d = bus.wr_data[i*DATA_W +: DATA_W];
                        fq[i].push_back(e);
                    end
                end
                m_ovf = (bus.err_clear ? '0 : m_ovf) | (bus.wr_valid & full);
                m_rdv = bus.rsp_valid;
                m_rdd = bus.rsp_data;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            check("wr_ready", 32'(bus.wr_ready), 32'(exp_ready()));
            check("cmd_valid", 32'(bus.cmd_valid), 32'(m_cv));
            if (m_cv) begin
                check("cmd_we", 32'(bus.cmd_we), 32'(m_we));
                check("cmd_addr", 32'(bus.cmd_addr), 32'(m_addr));
                if (m_we) check("cmd_wdata", 32'(bus.cmd_wdata), 32'(m_wd));
            end
            check("rd_ready", 32'(bus.rd_ready), 32'(m_rd_ready()));
            check("rd_data_valid", 32'(bus.rd_data_valid), 32'(m_rdv));
            if (m_rdv) check("rd_data", 32'(bus.rd_data), 32'(m_rdd));
            check("wr_overflow", 32'(bus.wr_overflow), 32'(m_ovf));
        end
    end

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] a;
    } iss_t;

    iss_t issued[$];

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && bus.cmd_valid && bus.cmd_ready) issued.push_back({bus.cmd_we, bus.cmd_addr});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int ch, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.wr_addr[ch*ADDR_W +: ADDR_W] = a;
        bus.wr_data[ch*DATA_W +: DATA_W] = d;
    endtask

    initial begin : stimulus
        int writes_seen;
        bus.wr_valid  = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_valid  = 1'b0;
        bus.rd_addr   = '0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.err_clear = 1'b0;

        #2;
        check("reset_wr_ready", 32'(bus.wr_ready), 32'h3);
        check("reset_cmd_valid", 32'(bus.cmd_valid), 32'h0);
        check("reset_rd_data_valid", 32'(bus.rd_data_valid), 32'h0);
        check("reset_wr_overflow", 32'(bus.wr_overflow), 32'h0);
        #10 rst_n = 1'b1;
        tick();

        // Round-robin: three words per channel, no reads
        bus.cmd_ready = 1'b1;
        issued.delete();
        for (int k = 0; k < 3; k++) begin
            bus.wr_valid = 2'b11;
            set_wr(0, ADDR_W'(32'h100 + k), DATA_W'(32'hA000 + k));
            set_wr(1, ADDR_W'(32'h200 + k), DATA_W'(32'hB000 + k));
            tick();
        end
        bus.wr_valid = '0;
        tick(8);
        check("rr_count", 32'(issued.size()), 32'd6);
        for (int j = 0; j < 6; j++) begin
            if (j < issued.size())
                check("rr_order", 32'(issued[j].a), (j % 2 == 0) ? 32'h100 + 32'(j / 2) : 32'h200 + 32'(j / 2));
        end

        // Single write latency
        bus.wr_valid = 2'b01;
        set_wr(0, 20'h00010, 16'hABCD);
        tick();
        bus.wr_valid = '0;
        check("single_wr_lat1_valid", 32'(bus.cmd_valid), 32'h0);
        tick();
        check("single_wr_valid", 32'(bus.cmd_valid), 32'h1);
        check("single_wr_we", 32'(bus.cmd_we), 32'h1);
        check("single_wr_addr", 32'(bus.cmd_addr), 32'h00010);
        check("single_wr_data", 32'(bus.cmd_wdata), 32'hABCD);
        tick(2);

        // Read priority over non-empty FIFOs, then response path
        bus.cmd_ready = 1'b0;
        bus.wr_valid = 2'b11;
        set_wr(0, 20'h00300, 16'h3000);
        set_wr(1, 20'h00400, 16'h4000);
        tick();
        set_wr(0, 20'h00301, 16'h3001);
        set_wr(1, 20'h00401, 16'h4001);
        tick();
        bus.wr_valid = '0;
        tick();
        bus.rd_valid  = 1'b1;
        bus.rd_addr   = 20'h5A5A5;
        bus.cmd_ready = 1'b1;
        #1;
        check("rd_ready_same_cycle", 32'(bus.rd_ready), 32'h1);
        tick();
        bus.rd_valid = 1'b0;
        check("rd_cmd_valid", 32'(bus.cmd_valid), 32'h1);
        check("rd_cmd_we", 32'(bus.cmd_we), 32'h0);
        check("rd_cmd_addr", 32'(bus.cmd_addr), 32'h5A5A5);
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 16'h1234;
        tick();
        bus.rsp_valid = 1'b0;
        check("rsp_valid_lat", 32'(bus.rd_data_valid), 32'h1);
        check("rsp_data", 32'(bus.rd_data), 32'h1234);
        tick();
        check("rsp_valid_drop", 32'(bus.rd_data_valid), 32'h0);
        tick(6);

        // Overflow on ch1 with the command slot occupied and stalled
        bus.cmd_ready = 1'b0;
        bus.wr_valid = 2'b01;
        set_wr(0, 20'h00500, 16'h5000);
        tick();
        bus.wr_valid = '0;
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.wr_valid = 2'b10;
            set_wr(1, ADDR_W'(32'h600 + k), DATA_W'(32'h6000 + k));
            tick();
        end
        bus.wr_valid = '0;
        check("ovf_flag", 32'(bus.wr_overflow), 32'h2);
        check("ovf_wr_ready", 32'(bus.wr_ready), 32'h1);
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        check("ovf_cleared", 32'(bus.wr_overflow), 32'h0);
        bus.cmd_ready = 1'b1;
        tick(8);

        // Continuous reads with a write waiting on ch0
        bus.cmd_ready = 1'b0;
        bus.wr_valid = 2'b01;
        set_wr(0, 20'h00700, 16'h7000);
        tick();
        set_wr(0, 20'h00701, 16'h7001);
        tick();
        bus.wr_valid = '0;
        tick();
        issued.delete();
        bus.rd_valid  = 1'b1;
        bus.rd_addr   = 20'h00777;
        bus.cmd_ready = 1'b1;
        tick(12);
        check("starve_count", 32'(issued.size()), 32'd12);
        writes_seen = 0;
        for (int j = 1; j < issued.size(); j++) if (issued[j].we) writes_seen++;
`ifdef SRAM_ARB_STARVE_GUARD_EN
        check("starve_writes", 32'(writes_seen), 32'd1);
        if (issued.size() > 10) begin
            check("starve_read_before", 32'(issued[8].we), 32'h0);
            check("starve_forced_wr", 32'({issued[9].we, issued[9].a}), 32'({1'b1, 20'h00701}));
            check("starve_read_resume", 32'(issued[10].we), 32'h0);
        end
`else
        check("starve_writes", 32'(writes_seen), 32'd0);
`endif
        bus.rd_valid = 1'b0;
        tick(4);

        // Reset with a pending command and buffered data
        bus.cmd_ready = 1'b0;
        bus.wr_valid = 2'b11;
        set_wr(0, 20'h00800, 16'h8000);
        set_wr(1, 20'h00900, 16'h9000);
        tick();
        bus.wr_valid = '0;
        tick();
        check("pre_reset_cmd_valid", 32'(bus.cmd_valid), 32'h1);
        rst_n = 1'b0;
        #2;
        check("mid_reset_cmd_valid", 32'(bus.cmd_valid), 32'h0);
        check("mid_reset_cmd_we", 32'(bus.cmd_we), 32'h0);
        check("mid_reset_cmd_addr", 32'(bus.cmd_addr), 32'h0);
        check("mid_reset_cmd_wdata", 32'(bus.cmd_wdata), 32'h0);
        check("mid_reset_wr_ready", 32'(bus.wr_ready), 32'h3);
        check("mid_reset_overflow", 32'(bus.wr_overflow), 32'h0);
        check("mid_reset_rd_valid", 32'(bus.rd_data_valid), 32'h0);
        check("mid_reset_rd_data", 32'(bus.rd_data), 32'h0);
        bus.cmd_ready = 1'b1;
        #4 rst_n = 1'b1;
        issued.delete();
        tick(5);
        check("post_reset_no_stale", 32'(issued.size()), 32'd0);
        check("post_reset_cmd_valid", 32'(bus.cmd_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
